// File: rtl/bitlet_accumulator.sv
// bitlet_accumulator: consumer end of the Bitlet_CE output interface.
// Each beat carries one signed A.fix value per bit channel. Channel g is
// weighted by 2^g and the channels are summed (stage 1). The per-beat sums
// are accumulated into one partial sum per group (stage 2). acc_done closes
// a group; the result is then offered on a valid/ready port.
//
// Handshake: psum is offered while psum_vld is high and held stable until
// psum_vld && psum_rdy at a clock edge, which is the single point of
// transfer. The beat side (Asel_vld) has no ready and cannot be stalled.
// The controller must keep Asel_vld and acc_done low while busy is high.
// Any violation is dropped or ignored and raises the sticky err flag.
module bitlet_accumulator #(
    parameter int N_CH   = 4,
    parameter int W_FIX  = 8,
    parameter int N_BEAT = 64,
    parameter int W_ACC  = W_FIX + N_CH + $clog2(N_BEAT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    Asel_vld,
    input  logic [N_CH*W_FIX-1:0]   Asel_vec,
    input  logic                    acc_done,
    output logic                    psum_vld,
    output logic [W_ACC-1:0]        psum,
    input  logic                    psum_rdy,
    output logic                    busy,
    output logic                    err
);

    // ACC: collecting beats. DRAIN: pipeline emptying. OUT: result offered.
    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    // The DRAIN counter runs 0,1,2; the move to OUT happens on the edge that
    // sees 2, so psum_vld rises on the third edge after acc_done was sampled.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [W_ACC-1:0] sum_q, sum_d;
    logic             sum_vq, sum_vd;
    logic [W_ACC-1:0] acc_q, acc_d;
    logic [W_ACC-1:0] psum_q, psum_d;
    logic             psum_vld_q, psum_vld_d;
    logic             err_q, err_d;
    logic [W_ACC-1:0] beat_sum;

    // Stage-1 combinational sum: sign-extend each channel and weight it by 2^g.
    always_comb begin
        logic [W_FIX-1:0] a;
        logic [W_ACC-1:0] term;
        beat_sum = '0;
        a        = '0;
        term     = '0;
        for (int g = 0; g < N_CH; g++) begin
            a        = Asel_vec[g*W_FIX +: W_FIX];
            term     = {{(W_ACC-W_FIX){a[W_FIX-1]}}, a};
            beat_sum = beat_sum + (term << g);
        end
    end

    // Next-state logic for the pipeline, accumulator, FSM and error flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        sum_vd     = 1'b0;
        acc_d      = acc_q;
        psum_d     = psum_q;
        psum_vld_d = psum_vld_q;
        err_d      = err_q;

        // Stage 2: fold the previous beat's sum into the accumulator. Wraps
        // modulo 2^W_ACC; W_ACC is sized so N_BEAT beats cannot overflow.
        if (sum_vq) begin
            acc_d = acc_q + sum_q;
        end

        if (state_q == ST_ACC) begin
            // A beat in the acc_done cycle still belongs to the group.
            if (Asel_vld) begin
                sum_d  = beat_sum;
                sum_vd = 1'b1;
            end
            if (acc_done) begin
                state_d = ST_DRAIN;
                cnt_d   = 2'd0;
            end
        end else begin
            // Beats and acc_done while busy are dropped and flagged.
            if (Asel_vld || acc_done) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_ACC: ;
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d    = ST_OUT;
                    psum_d     = acc_q;
                    psum_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_OUT: begin
                if (psum_rdy) begin
                    acc_d      = '0;
                    psum_vld_d = 1'b0;
                    state_d    = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State registers; reset and flush both return the block to an empty ACC.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q    <= ST_ACC;
            cnt_q      <= 2'd0;
            sum_q      <= '0;
            sum_vq     <= 1'b0;
            acc_q      <= '0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            sum_vq     <= sum_vd;
            acc_q      <= acc_d;
            psum_q     <= psum_d;
            psum_vld_q <= psum_vld_d;
            err_q      <= err_d;
        end
    end

    assign psum_vld = psum_vld_q;
    assign psum     = psum_q;
    assign busy     = (state_q != ST_ACC);
    assign err      = err_q;

endmodule
